// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard: one write port, two async read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_scoreboard #(
   parameter int WIDTH       = 64,
   parameter int NUM_REGS    = 32,
   parameter int ZERO_REG    = 31,
   parameter int ZERO_REG_EN = 1,
   localparam int ADDR_W     = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   input  logic                rsv_en,
   input  logic [ADDR_W-1:0]   rsv_addr,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   output logic [WIDTH-1:0]    rd_data_a,
   output logic                busy_a,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   output logic [WIDTH-1:0]    rd_data_b,
   output logic                busy_b,
   output logic [NUM_REGS-1:0] busy_vec
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic [WIDTH-1:0] regs_d [NUM_REGS];
   logic             busy_q [NUM_REGS];
   logic             busy_d [NUM_REGS];

   function automatic logic isZero(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG_EN != 0) && (addr == ZERO_IDX);
   endfunction

   // Reserve is applied after writeback so a same-edge re-issue leaves the register busy.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         busy_d[i] = busy_q[i];
         if (!((ZERO_REG_EN != 0) && (i == ZERO_REG))) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
               regs_d[i] = wr_data;
               busy_d[i] = 1'b0;
            end
            if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
               busy_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
            busy_q[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
            busy_q[i] <= busy_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_vec[i] = busy_q[i];
      end
   end

   always_comb begin
      rd_data_a = regs_q[rd_addr_a];
      busy_a    = busy_q[rd_addr_a];
      if (isZero(rd_addr_a)) begin
         rd_data_a = '0;
         busy_a    = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr_a) && !isZero(rd_addr_a)) begin
         rd_data_a = wr_data;
         busy_a    = rsv_en && (rsv_addr == rd_addr_a);
      end
`endif
   end

   always_comb begin
      rd_data_b = regs_q[rd_addr_b];
      busy_b    = busy_q[rd_addr_b];
      if (isZero(rd_addr_b)) begin
         rd_data_b = '0;
         busy_b    = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr_b) && !isZero(rd_addr_b)) begin
         rd_data_b = wr_data;
         busy_b    = rsv_en && (rsv_addr == rd_addr_b);
      end
`endif
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-register storage block for the CPU datapath: NUM_REGS registers of WIDTH bits, one synchronous write port, two asynchronous read ports, plus a per-register busy (scoreboard) bit.
- An issuing instruction reserves its destination register.
- The writeback clears the reservation.
- Decode reads both operands and their busy flags in the same cycle.
- One register index is optionally hardwired to zero (XZR).

Parameters:
WIDTH, 64, data width of each register
NUM_REGS, 32, number of registers; power of two, >= 2
ZERO_REG, 31, index of the hardwired-zero register
ZERO_REG_EN, 1, 1 = ZERO_REG reads zero and ignores writes/reserves; 0 = ordinary register
(localparam ADDR_W = $clog2(NUM_REGS))

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all registers and busy bits
wr_en  input  1  write enable for the writeback port
wr_addr  input  ADDR_W  writeback destination index
wr_data  input  WIDTH  writeback data
rsv_en  input  1  reserve enable (issue marks destination pending)
rsv_addr  input  ADDR_W  register index to mark busy
rd_addr_a  input  ADDR_W  read port A index
rd_data_a  output  WIDTH  read port A data
busy_a  output  1  busy bit of rd_addr_a
rd_addr_b  input  ADDR_W  read port B index
rd_data_b  output  WIDTH  read port B data
busy_b  output  1  busy bit of rd_addr_b
busy_vec  output  NUM_REGS  all busy bits, bit i = register i

Behaviour:
- Reset (asynchronous, active-high):
  - all registers = 0 and all busy bits = 0 immediately on assertion, held while asserted.
  - All outputs therefore read 0 during reset.
  - Reset asserted mid-operation discards any same-cycle write/reserve.
- Write:
  - on posedge clk with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - wr_en=0 holds all registers (hold-mux per bit).
- Reserve:
  - on posedge clk with rsv_en=1, busy[rsv_addr] <= 1.
  - Reserving an already-busy register leaves it busy (no count, single pending producer).
- Simultaneous wr_en and rsv_en to the same address:
  - data is written and busy ends 1 (reserve wins: a new producer was issued).
- Simultaneous wr_en and rsv_en to different addresses: both take effect independently.
- Reads:
  - combinational, zero latency.
  - rd_data_x = reg[rd_addr_x] and busy_x = busy[rd_addr_x], both reflecting state after the last clock edge.
  - Ports A and B are fully independent; both may address the same register.
- Zero register (ZERO_REG_EN=1):
  - writes and reserves to ZERO_REG are ignored.
  - reads of ZERO_REG return 0 with busy 0.
  - busy_vec[ZERO_REG] is always 0.
- Write-then-read:
  - without bypass, data written at edge N is visible on the read ports after edge N.
  - during cycle N a read of wr_addr returns the old value.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: when wr_en=1, wr_addr==rd_addr_x and the address is not the active zero register, rd_data_x = wr_data and busy_x = 0 in the same cycle, unless rsv_en=1 to the same address, in which case busy_x = 1.
- busy_vec is never bypassed.
- Undefined: no forwarding; reads always return stored state.

Test Plan:
- Reset with reg[5] written 64'hA0 -> assert reset mid-cycle: rd_data_a(addr 5)=0 and busy_vec=0 immediately, before the next edge.
- Write 64'h0000010204080001 to reg 3, then wr_en=0 with wr_data=64'hFFFF for 3 cycles -> port A and port B on addr 3 both read 64'h0000010204080001.
- Reserve reg 7, then 2 cycles idle -> busy_a=1 and busy_vec[7]=1. Write 64'h55 to reg 7 -> after the edge busy_a=0 and rd_data_a=64'h55.
- Same edge: wr_en to reg 9 with 64'h1234 and rsv_en to reg 9 -> rd_data=64'h1234, busy=1. Same edge: write reg 2 and reserve reg 4 -> busy_vec[2]=0, busy_vec[4]=1.
- Write 64'hDEAD and reserve at addr 31 (ZERO_REG_EN=1) -> rd_data=0, busy=0, busy_vec[31]=0. With ZERO_REG_EN=0 -> rd_data=64'hDEAD, busy=1.
- Same-cycle read of wr_addr 6 (old value 64'h1, new 64'h2) -> with REGFILE_BYPASS_EN rd_data_a=64'h2 and busy_a=0 in that cycle; without it rd_data_a=64'h1 until after the edge.
